// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch stage. Holds the PC, drives the instruction ROM
//            and registers each fetched word with its PC into IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    input  logic [15:0] rom_inst,
    output logic        rom_ce,
    output logic [15:0] rom_addr,
    output logic [15:0] id_pc,
    output logic [15:0] id_inst,
    output logic        id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic [15:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        rom_ce_q;
    logic        halted_q;
    logic        pc_oob;

    // Widened compare so MEM_WORDS = 65536 means "every PC is legal".
    assign pc_oob = (32'(pc_q) >= MEM_WORDS);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (stall) begin
                    // Hold everything; decode keeps any branch request asserted.
                end else if (branch_en) begin
                    pc_d       = branch_target;
                    id_pc_d    = 16'h0000;
                    id_inst_d  = 16'h0000;
                    id_valid_d = 1'b0;
                end else if (pc_oob) begin
                    state_d    = HALT;
                    id_pc_d    = 16'h0000;
                    id_inst_d  = 16'h0000;
                    id_valid_d = 1'b0;
                end else begin
                    id_pc_d    = pc_q;
                    id_inst_d  = rom_inst;
                    id_valid_d = 1'b1;
                    pc_d       = pc_q + 16'd1;
                end
            end
            HALT: begin
                if (branch_en && !stall) begin
                    pc_d    = branch_target;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            id_pc_q    <= 16'h0000;
            id_inst_q  <= 16'h0000;
            id_valid_q <= 1'b0;
            rom_ce_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            rom_ce_q   <= (state_d == RUN);
            halted_q   <= (state_d == HALT);
        end
    end

    assign rom_ce   = rom_ce_q;
    assign rom_addr = pc_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
    assign halted   = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed bench for inst_fetch; three instances share stimulus and
//            differ only in MEM_WORDS (1024, 6, 65536).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_en;
    logic [15:0] branch_target;

    logic [15:0] a_inst, a_addr, a_pc, a_iinst;
    logic        a_ce, a_valid, a_halted;
    logic [15:0] h_inst, h_addr, h_pc, h_iinst;
    logic        h_ce, h_valid, h_halted;
    logic [15:0] w_inst, w_addr, w_pc, w_iinst;
    logic        w_ce, w_valid, w_halted;

    int nchecks = 0;
    int nerrors = 0;

    // Six preloaded words, then a recognisable filler pattern.
    function automatic logic [15:0] rom_word(input logic [15:0] addr);
        case (addr)
            16'd0:   rom_word = 16'h3343;
            16'd1:   rom_word = 16'h0000;
            16'd2:   rom_word = 16'h3344;
            16'd3:   rom_word = 16'h3048;
            16'd4:   rom_word = 16'h0843;
            16'd5:   rom_word = 16'h0c43;
            default: rom_word = addr ^ 16'hA5A5;
        endcase
    endfunction

    assign a_inst = rom_word(a_addr);
    assign h_inst = rom_word(h_addr);
    assign w_inst = rom_word(w_addr);

    inst_fetch #(.RESET_PC(16'h0000), .MEM_WORDS(1024)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .rom_inst(a_inst),
        .rom_ce(a_ce), .rom_addr(a_addr), .id_pc(a_pc), .id_inst(a_iinst),
        .id_valid(a_valid), .halted(a_halted)
    );

    inst_fetch #(.RESET_PC(16'h0000), .MEM_WORDS(6)) u_halt (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .rom_inst(h_inst),
        .rom_ce(h_ce), .rom_addr(h_addr), .id_pc(h_pc), .id_inst(h_iinst),
        .id_valid(h_valid), .halted(h_halted)
    );

    inst_fetch #(.RESET_PC(16'h0000), .MEM_WORDS(65536)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .rom_inst(w_inst),
        .rom_ce(w_ce), .rom_addr(w_addr), .id_pc(w_pc), .id_inst(w_iinst),
        .id_valid(w_valid), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
        else begin
            nerrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_inst [0:5];
        exp_inst[0] = 16'h3343; exp_inst[1] = 16'h0000; exp_inst[2] = 16'h3344;
        exp_inst[3] = 16'h3048; exp_inst[4] = 16'h0843; exp_inst[5] = 16'h0c43;

        rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 16'h0000;

        // Reset held for two edges
        tick(); tick();
        check("rst_ce",     32'(a_ce),     32'h0);
        check("rst_addr",   32'(a_addr),   32'h0);
        check("rst_pc",     32'(a_pc),     32'h0);
        check("rst_inst",   32'(a_iinst),  32'h0);
        check("rst_valid",  32'(a_valid),  32'h0);
        check("rst_halted", 32'(a_halted), 32'h0);

        rst = 1'b0;
        tick();
        check("idle_ce",    32'(a_ce),    32'h1);
        check("idle_valid", 32'(a_valid), 32'h0);
        check("idle_addr",  32'(a_addr),  32'h0);

        // Sequential fetch of words 0..2
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_inst",  32'(a_iinst), 32'(exp_inst[i]));
            check("seq_pc",    32'(a_pc),    i);
            check("seq_valid", 32'(a_valid), 32'h1);
        end
        check("seq_addr", 32'(a_addr), 32'h3);

        // Stall three cycles with id_pc=2
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",   32'(a_pc),    32'h2);
            check("stall_inst", 32'(a_iinst), 32'h3344);
            check("stall_addr", 32'(a_addr),  32'h3);
        end
        stall = 1'b0;
        tick();
        check("resume_pc",   32'(a_pc),    32'h3);
        check("resume_inst", 32'(a_iinst), 32'h3048);
        check("resume_addr", 32'(a_addr),  32'h4);

        // Branch from pc=4 to 1
        branch_en = 1'b1; branch_target = 16'h0001;
        tick();
        check("br_valid", 32'(a_valid), 32'h0);
        check("br_inst",  32'(a_iinst), 32'h0);
        check("br_pc",    32'(a_pc),    32'h0);
        check("br_addr",  32'(a_addr),  32'h1);
        branch_en = 1'b0;
        tick();
        check("br_f1_inst", 32'(a_iinst), 32'h0000);
        check("br_f1_pc",   32'(a_pc),    32'h1);
        check("br_f1_val",  32'(a_valid), 32'h1);
        tick();
        check("br_f2_inst", 32'(a_iinst), 32'h3344);
        check("br_f2_pc",   32'(a_pc),    32'h2);

        // Stall and branch together: branch waits for stall to drop
        stall = 1'b1; branch_en = 1'b1; branch_target = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sb_addr", 32'(a_addr), 32'h3);
            check("sb_pc",   32'(a_pc),   32'h2);
        end
        stall = 1'b0;
        tick();
        check("sb_redir_addr",  32'(a_addr),  32'h0);
        check("sb_redir_valid", 32'(a_valid), 32'h0);
        branch_en = 1'b0;
        tick();
        check("sb_f_inst", 32'(a_iinst), 32'h3343);
        check("sb_f_pc",   32'(a_pc),    32'h0);

        // Halt scenario on the 6-word instance
        rst = 1'b1;
        tick();
        check("h_rst_valid", 32'(h_valid), 32'h0);
        check("h_rst_ce",    32'(h_ce),    32'h0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("h_seq_inst", 32'(h_iinst), 32'(exp_inst[i]));
            check("h_seq_pc",   32'(h_pc),    i);
        end
        check("h_pre_halted", 32'(h_halted), 32'h0);
        tick();
        check("h_halted", 32'(h_halted), 32'h1);
        check("h_ce",     32'(h_ce),     32'h0);
        check("h_valid",  32'(h_valid),  32'h0);
        check("h_inst",   32'(h_iinst),  32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("h_hold_addr",   32'(h_addr),   32'h6);
            check("h_hold_halted", 32'(h_halted), 32'h1);
        end
        branch_en = 1'b1; branch_target = 16'h0002;
        tick();
        check("h_exit_halted", 32'(h_halted), 32'h0);
        check("h_exit_ce",     32'(h_ce),     32'h1);
        check("h_exit_addr",   32'(h_addr),   32'h2);
        branch_en = 1'b0;
        tick();
        check("h_exit_inst",  32'(h_iinst), 32'h3344);
        check("h_exit_pc",    32'(h_pc),    32'h2);
        check("h_exit_valid", 32'(h_valid), 32'h1);

        // Wrap on the full-range instance
        branch_en = 1'b1; branch_target = 16'hFFFF;
        tick();
        check("w_addr_ffff", 32'(w_addr), 32'hFFFF);
        branch_en = 1'b0;
        tick();
        check("w_pc",     32'(w_pc),     32'hFFFF);
        check("w_inst",   32'(w_iinst),  32'h5A5A);
        check("w_valid",  32'(w_valid),  32'h1);
        check("w_addr0",  32'(w_addr),   32'h0000);
        check("w_halted", 32'(w_halted), 32'h0);

        // Reset during a stall (u_halt is halted on FFFF by now)
        stall = 1'b1;
        tick(); tick();
        check("h_oob_halted", 32'(h_halted), 32'h1);
        rst = 1'b1;
        tick();
        check("mr_ce",     32'(w_ce),     32'h0);
        check("mr_addr",   32'(w_addr),   32'h0);
        check("mr_pc",     32'(w_pc),     32'h0);
        check("mr_inst",   32'(w_iinst),  32'h0);
        check("mr_valid",  32'(w_valid),  32'h0);
        check("mr_halted", 32'(w_halted), 32'h0);
        check("mr_h_halted", 32'(h_halted), 32'h0);
        rst = 1'b0; stall = 1'b0;
        tick();
        check("mr_run_ce", 32'(w_ce), 32'h1);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that drives the instruction ROM and registers its output into the IF/ID pipeline register.
- Holds the program counter and generates the ROM chip-enable and word address.
- Captures the combinational ROM word together with its PC for the decode stage.
- Supports pipeline stall, taken-branch redirect with wrong-path squash, and an out-of-range fetch halt.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
MEM_WORDS, 1024, number of valid ROM words; PC >= MEM_WORDS is an illegal fetch.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous active-high reset.
stall  input  1  hold request from the downstream hazard unit.
branch_en  input  1  taken branch/jump from decode.
branch_target  input  16  redirect word address.
rom_inst  input  16  instruction word from ROM, combinational on rom_addr.
rom_ce  output  1  ROM chip enable (1 = enabled); registered.
rom_addr  output  16  ROM word address, equal to the current PC.
id_pc  output  16  PC of the instruction in IF/ID.
id_inst  output  16  instruction in IF/ID; 16'h0000 when not valid.
id_valid  output  1  IF/ID holds a real instruction.
halted  output  1  fetch stopped on an out-of-range PC.

Behaviour:
- FSM states: IDLE, RUN, HALT. rom_ce = 1 only in RUN. halted = 1 only in HALT.
- Reset (rst=1 at edge, overrides everything, including mid-stall or mid-halt):
  - state=IDLE, pc=RESET_PC.
  - id_pc=0, id_inst=0, id_valid=0, rom_ce=0, halted=0.
- IDLE: next edge with rst=0 -> RUN. PC is unchanged and IF/ID stays empty. The first real fetch is therefore one cycle after reset release.
- RUN, edge priority stall > branch_en > normal:
  - stall=1: pc, IF/ID, and state all hold. branch_en is ignored; decode holds branch_en asserted until stall drops.
  - branch_en=1: pc<=branch_target. IF/ID <= bubble (id_valid=0, id_inst=0, id_pc=0); the word at the old PC is squashed.
  - normal: id_pc<=pc, id_inst<=rom_inst, id_valid<=1, pc<=pc+1.
- Address arithmetic:
  - Word-addressed; increment is +1 modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
  - rom_addr = pc at all times.
- Out-of-range fetch:
  - In RUN with pc >= MEM_WORDS and no stall or branch: state<=HALT, IF/ID<=bubble, pc holds.
  - The range check takes effect the same cycle the PC becomes illegal, so no out-of-range word is ever captured as valid.
- HALT:
  - rom_ce=0; pc and IF/ID bubble hold.
  - branch_en=1 with stall=0: pc<=branch_target, state<=RUN. If the target is still out of range, the block re-halts next edge.
  - Otherwise exit only via rst.
- Stall while IF/ID is empty: the bubble holds (id_valid stays 0).
- branch_target is not range-checked at redirect; it is checked when fetched.

Test Plan:
- Reset/sequential fetch: ROM model preloaded 0x3343,0x0000,0x3344,0x3048,0x0843,0x0c43. Hold rst 2 cycles, then release.
  - All outputs are 0 during reset; rom_ce=1 one cycle after release.
  - On successive edges id_inst = 3343, 0000, 3344, 3048, 0843, 0c43 with id_pc = 0..5 and id_valid=1.
- Stall: assert stall for 3 cycles while id_pc=2.
  - id_pc=2, id_inst=3344, rom_addr=3 are held for 3 cycles.
  - Resumes with id_pc=3 / 3048; no instruction is duplicated or lost.
- Branch: with pc=4, pulse branch_en, target=1.
  - Next edge: id_valid=0, id_inst=0, rom_addr=1.
  - Following edges: id_inst=0000 (pc 1), 3344 (pc 2).
- Stall+branch together: stall=1, branch_en=1, target=0 for 2 cycles, then stall=0.
  - PC holds while stalled; redirect to 0 occurs on the first unstalled edge.
- Halt: MEM_WORDS=6, run from reset.
  - After id_pc=5/0c43, next edge halted=1, rom_ce=0, id_valid=0.
  - pc stays at 6 for 10 cycles.
  - Then branch_en target=2 -> halted=0, and the next edge gives id_inst=3344.
- Wrap and reset mid-run:
  - MEM_WORDS=65536, branch to FFFF; after the FFFF fetch, rom_addr=0000.
  - Assert rst during a stall -> all outputs 0 on the next edge.
